// File: rtl/sfu_pkg.sv
// Shared types and constants for the SFU output-side controller.
package sfu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sfu_out_state_e;

  localparam int unsigned SKID_DEPTH = 3;

  // Advances a skid-buffer pointer modulo SKID_DEPTH.
  function automatic logic [1:0] skid_ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(SKID_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/sfu_out_skid.sv
// Three-entry register FIFO that retimes registered FIFO read data onto the
// downstream ready/valid stream.
module sfu_out_skid
  import sfu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = skid_ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = skid_ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/sfu_out_ctrl.sv
// Job sequencer for the SFU output FIFO: admits cfg_len results, tracks exact
// FIFO occupancy, and drains read data through a skid buffer to the output.
module sfu_out_ctrl
  import sfu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_data_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  sfu_out_state_e        state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q, inflight_d;

  logic [1:0]            skid_cnt;
  logic [DATA_WIDTH-1:0] skid_head;
  logic                  out_hs;
  logic                  last_pos;

  sfu_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_data_valid),
    .push_data(fifo_data_out),
    .pop      (out_hs),
    .cnt      (skid_cnt),
    .head     (skid_head)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    occ_d      = occ_q;

    busy       = (state_q != IDLE);
    done       = (state_q == DONE);

    in_ready     = (state_q == RUN) && !fifo_full && (in_cnt_q != len_q);
    fifo_wr_en   = in_valid && in_ready;
    fifo_data_in = in_data;

    // Reads are throttled only by in-flight plus buffered entries, so a full
    // skid can never be overrun and out_ready never reaches the read request.
    fifo_rd_en = (state_q == RUN) && (occ_q != '0) &&
                 (({2'b00, inflight_q} + {1'b0, skid_cnt}) < 3'(SKID_DEPTH));
    inflight_d = fifo_rd_en;

    last_pos  = (out_cnt_q == len_q - LEN_WIDTH'(1));
    out_valid = (skid_cnt != 2'd0);
    out_data  = skid_head;
    out_last  = out_valid && last_pos;
    out_hs    = out_valid && out_ready;

    case ({fifo_wr_en, fifo_rd_en})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (fifo_wr_en) in_cnt_d  = in_cnt_q + LEN_WIDTH'(1);
    if (out_hs)     out_cnt_d = out_cnt_q + LEN_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (out_hs && last_pos) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  // Read data may only return for a read issued the previous cycle.
  assert property (@(posedge clk) disable iff (!rst_n) fifo_data_valid |-> inflight_q);

endmodule
